// File: rtl/cu_pkg.sv
// Shared definitions for the complex-unit command sequencer: op codes,
// FSM encoding and word-count constants.
package cu_pkg;

  typedef enum logic [1:0] {
    OP_SUM = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

  localparam int unsigned N_IN_WORDS  = 5;
  localparam int unsigned N_OUT_WORDS = 4;

  localparam logic [2:0] LAST_IN_WORD  = 3'(N_IN_WORDS - 1);
  localparam logic [1:0] LAST_OUT_WORD = 2'(N_OUT_WORDS - 1);

  // A DIV with a zero divisor has no meaningful result.
  function automatic logic div_by_zero(input logic [1:0] op,
                                       input logic [15:0] re,
                                       input logic [15:0] im);
    return (op == OP_DIV) && (re == 16'd0) && (im == 16'd0);
  endfunction

endpackage

// File: rtl/cu_word_ser.sv
// 64-bit parallel-load serializer emitting four 16-bit words MSB first
// under a valid/ready handshake.
module cu_word_ser
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        done
);

  logic [63:0] sreg_r;
  logic [1:0]  cnt_r;
  logic        valid_r;

  // Shift register, word counter and valid flag; advance only on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_r  <= 64'd0;
      cnt_r   <= 2'd0;
      valid_r <= 1'b0;
    end else if (load) begin
      sreg_r  <= data;
      cnt_r   <= 2'd0;
      valid_r <= 1'b1;
    end else if (valid_r && out_ready) begin
      if (cnt_r == LAST_OUT_WORD) begin
        cnt_r   <= 2'd0;
        valid_r <= 1'b0;
      end else begin
        sreg_r <= {sreg_r[47:0], 16'h0000};
        cnt_r  <= cnt_r + 2'd1;
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = sreg_r[63:48];
  assign done      = valid_r && out_ready && (cnt_r == LAST_OUT_WORD);

endmodule

// File: rtl/cu_seq.sv
// Command sequencer: loads op + four operands, holds them on the external
// complex arithmetic unit for SETTLE cycles, then streams the 64-bit result.
module cu_seq
  import cu_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] re1,
  output logic [15:0] im1,
  output logic [15:0] re2,
  output logic [15:0] im2,
  output logic [1:0]  itask,
  input  logic [31:0] outRe,
  input  logic [31:0] outIm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_r;
  state_t      next_state;
  logic [2:0]  wcnt_r;
  logic [3:0]  settle_cnt_r;
  logic [63:0] result_r;
  logic        ser_load_r;
  logic        ser_done;
  logic        accept;
  logic        settle_last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state_r;
    case (state_r)
      ST_LOAD: begin
        if (accept && (wcnt_r == LAST_IN_WORD)) next_state = ST_SETTLE;
        else                                    next_state = ST_LOAD;
      end
      ST_SETTLE: begin
        if (settle_last) next_state = ST_SEND;
        else             next_state = ST_SETTLE;
      end
      ST_SEND: begin
        if (ser_done) next_state = ST_LOAD;
        else          next_state = ST_SEND;
      end
      default: next_state = ST_LOAD;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    accept      = 1'b0;
    settle_last = 1'b0;
    case (state_r)
      ST_LOAD:   accept      = in_valid && in_ready;
      ST_SETTLE: settle_last = (settle_cnt_r == SETTLE_LAST);
      ST_SEND:   accept      = 1'b0;
      default:   accept      = 1'b0;
    endcase
  end

  // Operand steering, settle timing and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready     <= 1'b1;
      wcnt_r       <= 3'd0;
      settle_cnt_r <= 4'd0;
      itask        <= 2'd0;
      re1          <= 16'd0;
      im1          <= 16'd0;
      re2          <= 16'd0;
      im2          <= 16'd0;
      result_r     <= 64'd0;
      out_err      <= 1'b0;
      ser_load_r   <= 1'b0;
    end else begin
      in_ready <= (next_state == ST_LOAD);
      if (accept) begin
        case (wcnt_r)
          3'd0:    itask <= in_data[1:0];
          3'd1:    re1   <= in_data;
          3'd2:    im1   <= in_data;
          3'd3:    re2   <= in_data;
          3'd4:    im2   <= in_data;
          default: itask <= itask;
        endcase
        wcnt_r <= (wcnt_r == LAST_IN_WORD) ? 3'd0 : wcnt_r + 3'd1;
      end
      if (state_r == ST_SETTLE) begin
        settle_cnt_r <= settle_last ? 4'd0 : settle_cnt_r + 4'd1;
      end else begin
        settle_cnt_r <= 4'd0;
      end
      // Serializer loads one cycle after capture, from the result register.
      if (settle_last) begin
        out_err    <= div_by_zero(itask, re2, im2);
        result_r   <= div_by_zero(itask, re2, im2) ? 64'd0 : {outRe, outIm};
        ser_load_r <= 1'b1;
      end else begin
        ser_load_r <= 1'b0;
      end
    end
  end

  cu_word_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load_r),
    .data      (result_r),
    .out_ready (out_ready && (state_r == ST_SEND)),
    .out_valid (out_valid),
    .out_data  (out_data),
    .done      (ser_done)
  );

endmodule

// File: doc/cu_seq.md
CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 1: clock cycles operands are held on the complex-unit ports before results are captured (range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: command word valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts a command word.
REQ-006 SHALL have port in_data, input, 16: command word (word0 = op in [1:0], [15:2] ignored; words 1..4 = re1, im1, re2, im2).
REQ-007 SHALL have ports re1, im1, re2, im2, output, 16 each: operands driven to the complex arithmetic unit.
REQ-008 SHALL have port itask, output, 2: operation code to the complex arithmetic unit (0 SUM, 1 SUB, 2 MUL, 3 DIV).
REQ-009 SHALL have ports outRe, outIm, input, 32 each: results returned by the complex arithmetic unit.
REQ-010 SHALL have port out_valid, output, 1: result word valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts a result word.
REQ-012 SHALL have port out_data, output, 16: result word.
REQ-013 SHALL have port out_err, output, 1: divide-by-zero flag; valid whenever out_valid is high.

Function
REQ-014 SHALL implement states LOAD, SETTLE, SEND; transitions: LOAD->SETTLE after the 5th accepted word, SETTLE->SEND after SETTLE cycles, SEND->LOAD after the 4th accepted result word.
REQ-015 SHALL assert in_ready only in LOAD; a word is accepted when in_valid and in_ready are both high.
REQ-016 SHALL use a 3-bit word counter in LOAD (0..4) to steer accepted words into the itask, re1, im1, re2 and im2 registers in that order, wrapping to 0 on entry to SETTLE.
REQ-017 SHALL hold re1, im1, re2, im2 and itask stable from the cycle after acceptance until the next command overwrites them.
REQ-018 SHALL, on the last SETTLE cycle, capture {outRe, outIm} into a 64-bit result register and set out_err = (itask==3 && re2==0 && im2==0).
REQ-019 SHALL, when out_err is set, force every captured result word to 0x0000.
REQ-020 SHALL in SEND assert out_valid and present words in order outRe[31:16], outRe[15:0], outIm[31:16], outIm[15:0], advancing only when out_valid and out_ready are both high.
REQ-021 SHALL hold out_data and out_err stable while out_valid is high and out_ready is low.
REQ-022 SHALL, with SETTLE=1 and no backpressure, raise out_valid exactly 2 cycles after the clock edge that accepts word 4.
REQ-023 SHALL ignore in_valid outside LOAD and ignore out_ready outside SEND; no command is dropped or duplicated.
REQ-024 SHALL accept back-to-back commands: in_ready rises in the cycle after the 4th result word is accepted.

Reset
REQ-025 SHALL, when rst is high at a clock edge, enter LOAD with word and result counters at 0, all operand registers, itask, the result register and out_err at 0, in_ready=1, out_valid=0, and out_data=0.
REQ-026 SHALL abandon any partially loaded command or partially sent result on reset, and SHALL NOT emit further words from it.

Structure
REQ-027 SHALL take the op codes (SUM, SUB, MUL, DIV), the state encoding and the word-count constants (5 input words, 4 output words) from a shared package cu_pkg.
REQ-028 SHALL contain one sub-module, cu_word_ser: a 64-bit load, 4x16-bit MSB-first serializer with valid/ready handling.
REQ-029 SHALL NOT contain complex arithmetic; the arithmetic unit is connected externally in the bench and system.

Verification
REQ-030 SHALL pass: SUM, words 0,3,4,1,2 -> out 0x0000,0x0004,0x0000,0x0006, out_err=0.
REQ-031 SHALL pass: MUL, words 2,3,4,1,2 -> out 0xFFFF,0xFFFB,0x0000,0x000A.
REQ-032 SHALL pass: DIV, words 3,5,7,0,0 -> out_err=1, out 0x0000 x4.
REQ-033 SHALL pass: SUM result with out_ready held low 3 cycles on the 2nd word -> out_data stays 0x0004 and no word is skipped.
REQ-034 SHALL pass: rst pulsed after 3 words are loaded, then a full SUB command 1,9,9,2,3 -> exactly one result 0x0000,0x0007,0x0000,0x0006.
REQ-035 SHALL pass: two back-to-back SUM commands with in_valid held high -> 8 result words in order, in_ready low throughout SETTLE and SEND.
